fifo_wr_arbiter: RTL

- Shares the single write port of the byte FIFO (fifo_buf) between two producers, e.g. keyboard scanner (ch0) and UART receiver (ch1).
- Each producer posts a one-cycle request. The block holds it in a one-entry pending register per channel.
- Arbitration is round-robin. The block issues single-cycle FIFO write pulses and never writes while the FIFO reports full.

---
 rtl/fifo_wr_arbiter_if.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the two producers, the write arbiter and the
// shared FIFO write port. The arbiter side uses the master modport.
interface fifo_wr_arbiter_if #(
    parameter int B = 8
);
    logic         req0;
    logic [B-1:0] data0;
    logic         busy0;
    logic         ovf0;
    logic         req1;
    logic [B-1:0] data1;
    logic         busy1;
    logic         ovf1;
    logic         ovf_clr;
    logic         fifo_full;
    logic         fifo_wr;
    logic [B-1:0] fifo_w_data;
    logic         grant_id;

    modport master (
        input  req0, data0, req1, data1, ovf_clr, fifo_full,
        output busy0, ovf0, busy1, ovf1, fifo_wr, fifo_w_data, grant_id
    );

    modport slave (
        output req0, data0, req1, data1, ovf_clr, fifo_full,
        input  busy0, ovf0, busy1, ovf1, fifo_wr, fifo_w_data, grant_id
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port between two producers,
// each buffered by a one-entry pending register with a sticky overflow flag.
module fifo_wr_arbiter #(
    parameter int B         = 8,
    parameter bit PRIO_INIT = 1'b0
) (
    input logic              clk,
    input logic              reset,
    fifo_wr_arbiter_if.master bus
);

    typedef enum logic [1:0] {
        IDLE,
        WR,
        SETTLE
    } state_t;

    state_t       state;
    logic         prio;
    logic         busy0_q;
    logic         busy1_q;
    logic         ovf0_q;
    logic         ovf1_q;
    logic [B-1:0] pend0;
    logic [B-1:0] pend1;
    logic         wr_q;
    logic [B-1:0] wdata_q;
    logic         gid_q;

    logic         grant_en;
    logic         grant_ch;
    logic         grant0;
    logic         grant1;
    logic         ovf_evt0;
    logic         ovf_evt1;

    // The pointer only matters when both channels are waiting.
    always_comb begin
        grant_en = (state == IDLE) && !bus.fifo_full && (busy0_q || busy1_q);
        grant_ch = (busy0_q && busy1_q) ? prio : busy1_q;
        grant0   = grant_en && !grant_ch;
        grant1   = grant_en && grant_ch;
        ovf_evt0 = bus.req0 && busy0_q && !grant0;
        ovf_evt1 = bus.req1 && busy1_q && !grant1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            prio    <= PRIO_INIT;
            gid_q   <= PRIO_INIT;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            busy0_q <= 1'b0;
            busy1_q <= 1'b0;
            ovf0_q  <= 1'b0;
            ovf1_q  <= 1'b0;
            pend0   <= '0;
            pend1   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        wr_q    <= 1'b1;
                        wdata_q <= grant_ch ? pend1 : pend0;
                        gid_q   <= grant_ch;
                        prio    <= ~grant_ch;
                        state   <= WR;
                    end
                end
                WR: begin
                    wr_q  <= 1'b0;
                    state <= SETTLE;
                end
                SETTLE: begin
                    state <= IDLE;
                end
                default: begin
                    wr_q  <= 1'b0;
                    state <= IDLE;
                end
            endcase

            // A request on the grant edge refills the slot being emptied.
            if (bus.req0 && (!busy0_q || grant0)) begin
                pend0   <= bus.data0;
                busy0_q <= 1'b1;
            end else if (grant0) begin
                busy0_q <= 1'b0;
            end

            if (bus.req1 && (!busy1_q || grant1)) begin
                pend1   <= bus.data1;
                busy1_q <= 1'b1;
            end else if (grant1) begin
                busy1_q <= 1'b0;
            end

            // An overflow on the clear edge takes precedence.
            if (ovf_evt0)
                ovf0_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf0_q <= 1'b0;

            if (ovf_evt1)
                ovf1_q <= 1'b1;
            else if (bus.ovf_clr)
                ovf1_q <= 1'b0;
        end
    end

    assign bus.busy0       = busy0_q;
    assign bus.busy1       = busy1_q;
    assign bus.ovf0        = ovf0_q;
    assign bus.ovf1        = ovf1_q;
    assign bus.fifo_wr     = wr_q;
    assign bus.fifo_w_data = wdata_q;
    assign bus.grant_id    = gid_q;

endmodule
